tc_ram_copy_engine: RTL

//  Block-copy (memmove) engine sitting directly upstream of the dual-load RAM.

---
 rtl/tc_ram_copy_engine.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/tc_ram_copy_engine.sv
// ---------------------------------------------------------------------------
// tc_ram_copy_engine
//
// Block-copy (memmove) engine placed directly in front of the dual-load RAM.
// While idle, the host request lines pass straight through to the RAM ports.
// Once a copy starts, the engine owns both RAM ports. It reads through port 1
// and writes through port 0, moving one word per clock. Overlapping ranges
// where the destination lies above the source are copied backwards, so source
// words are read before they are overwritten.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   start, src, dst, len      copy request; operands are latched when start
//                             is sampled while idle
//   busy                      engine owns the RAM (COPY or DONE)
//   done                      one-cycle pulse when a copy finishes
//   err                       one-cycle pulse when a range is rejected
//   host_*                    host RAM request lines (dropped while busy)
//   host_stall                equals busy
//   ram_*                     RAM request lines; ram_out1 is the RAM's
//                             combinational port-1 read data
// ---------------------------------------------------------------------------
module tc_ram_copy_engine #(
    parameter int BIT_WIDTH = 16,
    parameter int BIT_DEPTH = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [15:0]          src,
    input  logic [15:0]          dst,
    input  logic [15:0]          len,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    input  logic                 host_load0,
    input  logic                 host_save,
    input  logic [15:0]          host_address0,
    input  logic [BIT_WIDTH-1:0] host_in,
    input  logic                 host_load1,
    input  logic [15:0]          host_address1,
    output logic                 host_stall,
    output logic                 ram_load0,
    output logic                 ram_save,
    output logic [15:0]          ram_address0,
    output logic [BIT_WIDTH-1:0] ram_in,
    output logic                 ram_load1,
    output logic [15:0]          ram_address1,
    input  logic [BIT_WIDTH-1:0] ram_out1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COPY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [16:0] DEPTH = 17'(BIT_DEPTH);

    state_t      state;
    state_t      state_next;
    logic [15:0] src_q;
    logic [15:0] dst_q;
    logic [15:0] len_q;
    logic [15:0] index;
    logic [15:0] off;
    logic        backward_q;
    logic        err_q;

    // The end addresses use 17 bits so that a range ending exactly at
    // BIT_DEPTH is accepted, and a range that wraps 16 bits is still rejected.
    logic [16:0] src_end;
    logic [16:0] dst_end;
    logic        range_bad;
    logic        go_backward;

    assign src_end     = {1'b0, src} + {1'b0, len};
    assign dst_end     = {1'b0, dst} + {1'b0, len};
    assign range_bad   = (src_end > DEPTH) || (dst_end > DEPTH);
    assign go_backward = ({1'b0, dst} > {1'b0, src}) && ({1'b0, dst} < src_end);

    // A backward copy walks from the top of the range down.
    assign off = backward_q ? (len_q - 16'd1 - index) : index;

    // State register and copy bookkeeping. The err pulse is registered, so it
    // appears in the cycle after the rejected start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            index      <= '0;
            backward_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state <= state_next;
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        src_q      <= src;
                        dst_q      <= dst;
                        len_q      <= len;
                        backward_q <= go_backward;
                        index      <= '0;
                        err_q      <= range_bad;
                    end
                end
                COPY:    index <= index + 16'd1;
                default: ;
            endcase
        end
    end

    // Next-state logic and RAM port steering. In IDLE the host drives the
    // RAM. In COPY the engine drives it, and the word read on port 1 is
    // written back through port 0 in the same cycle. The RAM samples writes
    // on the falling edge.
    always_comb begin
        state_next   = state;
        ram_load0    = 1'b0;
        ram_save     = 1'b0;
        ram_address0 = '0;
        ram_in       = '0;
        ram_load1    = 1'b0;
        ram_address1 = '0;

        case (state)
            IDLE: begin
                if (start && !range_bad) begin
                    state_next = (len == 16'd0) ? DONE : COPY;
                end
                ram_load0    = host_load0;
                ram_save     = host_save;
                ram_address0 = host_address0;
                ram_in       = host_in;
                ram_load1    = host_load1;
                ram_address1 = host_address1;
            end
            COPY: begin
                if (index == len_q - 16'd1) begin
                    state_next = DONE;
                end
                ram_load1    = 1'b1;
                ram_address1 = src_q + off;
                ram_save     = 1'b1;
                ram_address0 = dst_q + off;
                ram_in       = ram_out1;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // The RAM must never see a request while reset is held.
        if (rst) begin
            ram_load0    = 1'b0;
            ram_save     = 1'b0;
            ram_address0 = '0;
            ram_in       = '0;
            ram_load1    = 1'b0;
            ram_address1 = '0;
        end
    end

    assign busy       = (state == COPY) || (state == DONE);
    assign done       = (state == DONE);
    assign err        = err_q;
    assign host_stall = busy;

endmodule
